dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_pkg.sv | 28 ++
 rtl/dmem_arb_grant.sv | 24 ++
 rtl/dmem_arbiter.sv | 144 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: FSM states, requester IDs and
// RISC-V load/store funct3 codes.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    typedef enum logic {
        REQ_R0 = 1'b0,
        REQ_R1 = 1'b1
    } req_id_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    function automatic req_id_e other_req(input req_id_e id);
        return (id == REQ_R0) ? REQ_R1 : REQ_R0;
    endfunction

endpackage

// File: rtl/dmem_arb_grant.sv
// Combinational grant selection between the two requesters. On a tie the
// requester named by prio wins; a lone requester always wins.
module dmem_arb_grant
    import dmem_pkg::*;
(
    input  logic    r0_valid,
    input  logic    r1_valid,
    input  req_id_e prio,
    output logic    grant_any,
    output req_id_e grant_id
);

    // Pick the winner from the valids and the tie-break priority
    always_comb begin
        grant_any = r0_valid | r1_valid;
        if (r0_valid && r1_valid)
            grant_id = prio;
        else if (r1_valid)
            grant_id = REQ_R1;
        else
            grant_id = REQ_R0;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-ported data memory.
// r0 = core load/store unit, r1 = debug/DMA port. One access at a time,
// fixed two-cycle latency from acceptance to the response strobe.
// Macro DMEM_ARB_RR_EN: round-robin tie-break; otherwise r0 has fixed priority.
//
// state | meaning
// IDLE  | waiting for a request; ready offered to the winner
// ISSUE | registered request driven onto the memory port
// RESP  | rvalid pulse and rdata to the granted requester
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  r0_valid,
    output logic                  r0_ready,
    input  logic                  r0_we,
    input  logic [DM_ADDRESS-1:0] r0_addr,
    input  logic [DATA_W-1:0]     r0_wdata,
    input  logic [2:0]            r0_funct3,
    output logic                  r0_rvalid,
    output logic [DATA_W-1:0]     r0_rdata,

    input  logic                  r1_valid,
    output logic                  r1_ready,
    input  logic                  r1_we,
    input  logic [DM_ADDRESS-1:0] r1_addr,
    input  logic [DATA_W-1:0]     r1_wdata,
    input  logic [2:0]            r1_funct3,
    output logic                  r1_rvalid,
    output logic [DATA_W-1:0]     r1_rdata,

    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DM_ADDRESS-1:0] mem_a,
    output logic [DATA_W-1:0]     mem_wd,
    output logic [2:0]            mem_funct3,
    input  logic [DATA_W-1:0]     mem_rd
);

    state_e                  state;
    logic                    we_q;
    logic [DM_ADDRESS-1:0]   addr_q;
    logic [DATA_W-1:0]       wdata_q;
    logic [2:0]              f3_q;
    req_id_e                 gid_q;
    logic                    rvalid0_q;
    logic                    rvalid1_q;
    logic [DATA_W-1:0]       rdata0_q;
    logic [DATA_W-1:0]       rdata1_q;

    req_id_e                 prio;
    logic                    grant_any;
    req_id_e                 grant_id;
    logic                    accept;
    logic                    issue;

    dmem_arb_grant u_grant (
        .r0_valid  (r0_valid),
        .r1_valid  (r1_valid),
        .prio      (prio),
        .grant_any (grant_any),
        .grant_id  (grant_id)
    );

    // Ready, memory strobes and rvalid are gated by rst_n so an aborted
    // access releases the memory in the very cycle reset is sampled low.
    assign accept     = rst_n && (state == IDLE) && grant_any;
    assign r0_ready   = accept && (grant_id == REQ_R0);
    assign r1_ready   = accept && (grant_id == REQ_R1);

    assign issue      = rst_n && (state == ISSUE);
    assign mem_read   = issue && !we_q;
    assign mem_write  = issue && we_q;
    assign mem_a      = issue ? addr_q  : '0;
    assign mem_wd     = issue ? wdata_q : '0;
    assign mem_funct3 = issue ? f3_q    : 3'b000;

    assign r0_rvalid  = rst_n && rvalid0_q;
    assign r1_rvalid  = rst_n && rvalid1_q;
    assign r0_rdata   = rdata0_q;
    assign r1_rdata   = rdata1_q;

`ifdef DMEM_ARB_RR_EN
    // Tie-break pointer: after every acceptance the other requester gets priority
    always_ff @(posedge clk) begin
        if (!rst_n)
            prio <= REQ_R0;
        else if (accept)
            prio <= other_req(grant_id);
    end
`else
    assign prio = REQ_R0;
`endif

    // Access FSM with request capture and per-requester response registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            f3_q      <= 3'b000;
            gid_q     <= REQ_R0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        gid_q   <= grant_id;
                        we_q    <= (grant_id == REQ_R1) ? r1_we     : r0_we;
                        addr_q  <= (grant_id == REQ_R1) ? r1_addr   : r0_addr;
                        wdata_q <= (grant_id == REQ_R1) ? r1_wdata  : r0_wdata;
                        f3_q    <= (grant_id == REQ_R1) ? r1_funct3 : r0_funct3;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Stores answer with zero data; loads latch the memory word
                    if (gid_q == REQ_R0) begin
                        rvalid0_q <= 1'b1;
                        rdata0_q  <= we_q ? '0 : mem_rd;
                    end else begin
                        rvalid1_q <= 1'b1;
                        rdata1_q  <= we_q ? '0 : mem_rd;
                    end
                    state <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter: single-requester vector table plus
// hand sequences for reset, abort, ties, back-to-back and data hold.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        r0_valid, r1_valid, r0_ready, r1_ready;
    logic        r0_we, r1_we;
    logic [8:0]  r0_addr, r1_addr;
    logic [31:0] r0_wdata, r1_wdata;
    logic [2:0]  r0_funct3, r1_funct3;
    logic        r0_rvalid, r1_rvalid;
    logic [31:0] r0_rdata, r1_rdata;
    logic        mem_read, mem_write;
    logic [8:0]  mem_a;
    logic [31:0] mem_wd;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_rd;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_rd [2];

    always #5 clk = ~clk;

    dmem_arbiter #(.DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we), .r0_addr(r0_addr),
        .r0_wdata(r0_wdata), .r0_funct3(r0_funct3), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we), .r1_addr(r1_addr),
        .r1_wdata(r1_wdata), .r1_funct3(r1_funct3), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_a(mem_a), .mem_wd(mem_wd),
        .mem_funct3(mem_funct3), .mem_rd(mem_rd)
    );

    typedef struct {
        int          gid;
        logic        we;
        logic [8:0]  a;
        logic [31:0] wd;
        logic [2:0]  f3;
        logic [31:0] mrd;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input int gid, input logic we, input logic [8:0] a,
                                input logic [31:0] wd, input logic [2:0] f3,
                                input logic [31:0] mrd, input logic [31:0] exp_rdata);
        vec_t v;
        v.gid = gid; v.we = we; v.a = a; v.wd = wd; v.f3 = f3;
        v.mrd = mrd; v.exp_rdata = exp_rdata;
        return v;
    endfunction

    task automatic idle_inputs();
        r0_valid = 0; r1_valid = 0;
        r0_we = 0; r1_we = 0;
        r0_addr = 9'h155; r1_addr = 9'h0AA;
        r0_wdata = 32'h5A5A5A5A; r1_wdata = 32'hA5A5A5A5;
        r0_funct3 = 3'b111; r1_funct3 = 3'b110;
    endtask

    // One complete access from IDLE; the other requester's fields carry decoys
    task automatic run_vec(input int idx, input vec_t v);
        @(negedge clk);
        idle_inputs();
        if (v.gid == 0) begin
            r0_valid = 1; r0_we = v.we; r0_addr = v.a; r0_wdata = v.wd; r0_funct3 = v.f3;
            r1_we = ~v.we;
        end else begin
            r1_valid = 1; r1_we = v.we; r1_addr = v.a; r1_wdata = v.wd; r1_funct3 = v.f3;
            r0_we = ~v.we;
        end
        mem_rd = v.mrd;
        #1;
        chk($sformatf("v%0d r0_ready", idx), {31'b0, r0_ready}, (v.gid == 0) ? 1 : 0);
        chk($sformatf("v%0d r1_ready", idx), {31'b0, r1_ready}, (v.gid == 1) ? 1 : 0);
        chk($sformatf("v%0d rvalid_idle", idx), {30'b0, r1_rvalid, r0_rvalid}, 0);
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        #1;
        chk($sformatf("v%0d mem_read", idx),  {31'b0, mem_read},  {31'b0, ~v.we});
        chk($sformatf("v%0d mem_write", idx), {31'b0, mem_write}, {31'b0, v.we});
        chk($sformatf("v%0d mem_a", idx),     {23'b0, mem_a},     {23'b0, v.a});
        chk($sformatf("v%0d mem_wd", idx),    mem_wd,             v.wd);
        chk($sformatf("v%0d mem_funct3", idx), {29'b0, mem_funct3}, {29'b0, v.f3});
        chk($sformatf("v%0d ready_issue", idx), {30'b0, r1_ready, r0_ready}, 0);
        @(posedge clk);
        @(negedge clk);
        mem_rd = 32'hFFFF0000;
        exp_rd[v.gid] = v.exp_rdata;
        chk($sformatf("v%0d r0_rvalid", idx), {31'b0, r0_rvalid}, (v.gid == 0) ? 1 : 0);
        chk($sformatf("v%0d r1_rvalid", idx), {31'b0, r1_rvalid}, (v.gid == 1) ? 1 : 0);
        chk($sformatf("v%0d r0_rdata", idx),  r0_rdata, exp_rd[0]);
        chk($sformatf("v%0d r1_rdata", idx),  r1_rdata, exp_rd[1]);
        chk($sformatf("v%0d mem_idle_resp", idx), {30'b0, mem_write, mem_read}, 0);
    endtask

    initial begin
        int order [4];
        int exp_order [4];
        int got, both, seen, acc_n;
        int acc_at [8];

        vecs[0] = mk(0, 0, 9'h010, 32'h00000000, 3'b010, 32'hDEADBEEF, 32'hDEADBEEF); // r0 LW
        vecs[1] = mk(1, 1, 9'h003, 32'h000000A5, 3'b000, 32'h11111111, 32'h00000000); // r1 SB
        vecs[2] = mk(0, 1, 9'h1FC, 32'hCAFEF00D, 3'b010, 32'h22222222, 32'h00000000); // r0 SW
        vecs[3] = mk(1, 0, 9'h022, 32'h00001234, 3'b001, 32'h0000FFFF, 32'h0000FFFF); // r1 LH
        vecs[4] = mk(0, 0, 9'h1FF, 32'h00000000, 3'b100, 32'h000000FF, 32'h000000FF); // r0 LBU
        vecs[5] = mk(0, 0, 9'h040, 32'h00000000, 3'b010, 32'h12345678, 32'h12345678); // r0 LW
        vecs[6] = mk(1, 0, 9'h044, 32'h00000000, 3'b010, 32'hAAAAAAAA, 32'hAAAAAAAA); // r1 LW
        vecs[7] = mk(1, 1, 9'h046, 32'h0000BEEF, 3'b001, 32'h33333333, 32'h00000000); // r1 SH
        vecs[8] = mk(0, 0, 9'h048, 32'h00000000, 3'b010, 32'h55555555, 32'h55555555); // r0 LW

`ifdef DMEM_ARB_RR_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0};
`endif

        // Reset with both requesters pushing
        idle_inputs();
        mem_rd = 32'hFFFFFFFF;
        rst_n = 0;
        r0_valid = 1; r1_valid = 1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst ready", {30'b0, r1_ready, r0_ready}, 0);
        chk("rst rvalid", {30'b0, r1_rvalid, r0_rvalid}, 0);
        chk("rst mem_en", {30'b0, mem_write, mem_read}, 0);
        chk("rst r0_rdata", r0_rdata, 0);
        chk("rst r1_rdata", r1_rdata, 0);
        chk("rst mem_a", {23'b0, mem_a}, 0);
        idle_inputs();
        rst_n = 1;
        exp_rd[0] = 0; exp_rd[1] = 0;

        for (int i = 0; i < 9; i++) begin
            run_vec(i, vecs[i]);
            if (i == 7) chk("hold r0_rdata", r0_rdata, 32'h12345678);
        end

        // Reset during ISSUE of an r0 store
        @(negedge clk);
        r0_valid = 1; r0_we = 1; r0_addr = 9'h100; r0_wdata = 32'h0BADF00D; r0_funct3 = 3'b010;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("abort issue mem_write", {31'b0, mem_write}, 1);
        rst_n = 0;
        r0_valid = 1;
        #1;
        chk("abort same-cycle mem_write", {31'b0, mem_write}, 0);
        chk("abort same-cycle mem_a", {23'b0, mem_a}, 0);
        chk("abort same-cycle ready", {30'b0, r1_ready, r0_ready}, 0);
        @(posedge clk);
        @(negedge clk);
        chk("abort next rvalid", {30'b0, r1_rvalid, r0_rvalid}, 0);
        chk("abort next mem_en", {30'b0, mem_write, mem_read}, 0);
        chk("abort next r0_rdata", r0_rdata, 0);
        chk("abort next r1_rdata", r1_rdata, 0);
        idle_inputs();
        rst_n = 1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (r0_rvalid) seen++;
        end
        chk("abort no rvalid", seen, 0);

        // Tie with both valid held: pointer is fresh from reset
        @(negedge clk);
        r0_valid = 1; r1_valid = 1;
        r0_we = 0; r1_we = 0; r0_funct3 = 3'b010; r1_funct3 = 3'b010;
        got = 0; both = 0;
        for (int i = 0; i < 30 && got < 4; i++) begin
            #1;
            if (r0_ready && r1_ready) both++;
            if (r0_ready) begin order[got] = 0; got++; end
            else if (r1_ready) begin order[got] = 1; got++; end
            @(negedge clk);
        end
        idle_inputs();
        chk("tie grants", got, 4);
        chk("tie both ready", both, 0);
        for (int i = 0; i < 4; i++)
            if (i < got) chk($sformatf("tie order[%0d]", i), order[i], exp_order[i]);
        repeat (3) @(negedge clk);

        // Back-to-back: r0 held continuously
        r0_valid = 1; r0_we = 0; r0_addr = 9'h080; r0_funct3 = 3'b010;
        acc_n = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (r0_ready && acc_n < 8) begin acc_at[acc_n] = i; acc_n++; end
            @(negedge clk);
        end
        idle_inputs();
        chk("b2b count", acc_n, 4);
        for (int i = 1; i < 4; i++)
            if (i < acc_n) chk($sformatf("b2b spacing[%0d]", i), acc_at[i] - acc_at[i-1], 3);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
